// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the FIFO -> FFT magnitude path: gates sample writes, arms the FFT,
// tracks unload and counts frames. Optional peak-bin tracker under FFT_FRAME_CTRL_PEAK_EN.
module fft_frame_ctrl #(
   parameter int unsigned N_LOG2      = 10,
   parameter int unsigned FILL_THRESH = 1023,
   parameter int unsigned TIMEOUT     = 8192
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        tick_640k,
   input  logic [10:0] fifo_data_count,
   input  logic        fifo_full,
   input  logic        fifo_empty,
   input  logic        fft_rfd,
   input  logic [9:0]  fft_xn_index,
   input  logic        fft_done,
   input  logic        fft_dv,
   input  logic [9:0]  fft_xk_index,
   input  logic [9:0]  fft_abs,
   output logic        fifo_wr_en,
   output logic        fifo_rd_en,
   output logic        fft_start,
   output logic        frame_done,
   output logic [15:0] frame_count,
   output logic [2:0]  state_o,
   output logic        overflow_err,
   output logic        underflow_err,
   output logic        timeout_err
`ifdef FFT_FRAME_CTRL_PEAK_EN
   ,
   output logic [9:0]  peak_index,
   output logic [9:0]  peak_abs,
   output logic        peak_valid
`endif
);

   localparam int unsigned FRAME_LEN = 2 ** N_LOG2;
   localparam int unsigned WD_W      = $clog2(TIMEOUT + 1);
   localparam logic [9:0]  LAST_IDX  = 10'(FRAME_LEN - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FILL      = 3'd1,
      ST_LOAD      = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_UNLOAD    = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic              wr_en_q, wr_en_d;
   logic              fft_start_q, fft_start_d;
   logic              frame_done_q, frame_done_d;
   logic [15:0]       frame_count_q, frame_count_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              timeout_q, timeout_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;
   logic              active;
   logic              timed_out;

   assign active    = (state_q != ST_IDLE);
   assign timed_out = (wdog_q == WD_W'(TIMEOUT - 1)) &&
                      ((state_q == ST_LOAD) || (state_q == ST_WAIT_DONE) || (state_q == ST_UNLOAD));

   // FIFO reads follow the FFT's demand directly so no sample slot is lost
   assign fifo_rd_en = fft_rfd & (state_q == ST_LOAD);

   always_comb begin
      state_d       = state_q;
      fft_start_d   = fft_start_q;
      frame_done_d  = 1'b0;
      frame_count_d = frame_count_q;
      timeout_d     = timeout_q;
      wr_en_d       = tick_640k & active & ~fifo_full;
      overflow_d    = overflow_q | (tick_640k & active & fifo_full);
      underflow_d   = underflow_q | (fft_rfd & fifo_empty & (state_q == ST_LOAD));

      case (state_q)
         ST_IDLE: begin
            fft_start_d = 1'b0;
            if (enable) state_d = ST_FILL;
         end
         ST_FILL: begin
            if (fifo_data_count >= 11'(FILL_THRESH)) begin
               fft_start_d = 1'b1;
               state_d     = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (fft_rfd && (fft_xn_index == LAST_IDX)) begin
               fft_start_d = 1'b0;
               state_d     = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            // a pipelined core may present bin 0 before (or without) fft_done
            if (fft_done || (fft_dv && (fft_xk_index == 10'd0))) state_d = ST_UNLOAD;
         end
         ST_UNLOAD: begin
            if (fft_dv && (fft_xk_index == LAST_IDX)) begin
               frame_done_d  = 1'b1;
               frame_count_d = frame_count_q + 16'd1;
               state_d       = enable ? ST_FILL : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (timed_out) begin
         timeout_d     = 1'b1;
         fft_start_d   = 1'b0;
         frame_done_d  = 1'b0;
         frame_count_d = frame_count_q;
         state_d       = ST_FILL;
      end

      wdog_d = ((state_d != state_q) || !active || (state_q == ST_FILL)) ? '0 : wdog_q + WD_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         wr_en_q       <= 1'b0;
         fft_start_q   <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_count_q <= '0;
         overflow_q    <= 1'b0;
         underflow_q   <= 1'b0;
         timeout_q     <= 1'b0;
         wdog_q        <= '0;
      end else begin
         state_q       <= state_d;
         wr_en_q       <= wr_en_d;
         fft_start_q   <= fft_start_d;
         frame_done_q  <= frame_done_d;
         frame_count_q <= frame_count_d;
         overflow_q    <= overflow_d;
         underflow_q   <= underflow_d;
         timeout_q     <= timeout_d;
         wdog_q        <= wdog_d;
      end
   end

   assign fifo_wr_en    = wr_en_q;
   assign fft_start     = fft_start_q;
   assign frame_done    = frame_done_q;
   assign frame_count   = frame_count_q;
   assign state_o       = state_q;
   assign overflow_err  = overflow_q;
   assign underflow_err = underflow_q;
   assign timeout_err   = timeout_q;

`ifdef FFT_FRAME_CTRL_PEAK_EN
   // Peak search over the positive-frequency bins, excluding DC; strict > keeps the lower index on ties
   logic [9:0] pk_max_q, pk_max_d;
   logic [9:0] pk_idx_q, pk_idx_d;
   logic [9:0] peak_index_q, peak_index_d;
   logic [9:0] peak_abs_q, peak_abs_d;
   logic       peak_valid_q, peak_valid_d;

   always_comb begin
      pk_max_d     = pk_max_q;
      pk_idx_d     = pk_idx_q;
      peak_index_d = peak_index_q;
      peak_abs_d   = peak_abs_q;
      peak_valid_d = frame_done_d;
      if (state_q != ST_UNLOAD) begin
         pk_max_d = '0;
         pk_idx_d = '0;
      end else if (fft_dv && (fft_xk_index != 10'd0) && (fft_xk_index < 10'(FRAME_LEN / 2)) &&
                   (fft_abs > pk_max_q)) begin
         pk_max_d = fft_abs;
         pk_idx_d = fft_xk_index;
      end
      if (frame_done_d) begin
         peak_index_d = pk_idx_d;
         peak_abs_d   = pk_max_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pk_max_q     <= '0;
         pk_idx_q     <= '0;
         peak_index_q <= '0;
         peak_abs_q   <= '0;
         peak_valid_q <= 1'b0;
      end else begin
         pk_max_q     <= pk_max_d;
         pk_idx_q     <= pk_idx_d;
         peak_index_q <= peak_index_d;
         peak_abs_q   <= peak_abs_d;
         peak_valid_q <= peak_valid_d;
      end
   end

   assign peak_index = peak_index_q;
   assign peak_abs   = peak_abs_q;
   assign peak_valid = peak_valid_q;
`else
   logic unused_abs;
   assign unused_abs = ^fft_abs;
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with a small FIFO model and a scripted FFT core.
module tb_fft_frame_ctrl;

   localparam int CLK_P = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        tick_640k = 1'b0;
   logic [10:0] fifo_data_count = '0;
   logic        fifo_full = 1'b0;
   logic        fifo_empty = 1'b1;
   logic        fft_rfd;
   logic [9:0]  fft_xn_index;
   logic        fft_done;
   logic        fft_dv;
   logic [9:0]  fft_xk_index;
   logic [9:0]  fft_abs;
   logic        fifo_wr_en;
   logic        fifo_rd_en;
   logic        fft_start;
   logic        frame_done;
   logic [15:0] frame_count;
   logic [2:0]  state_o;
   logic        overflow_err;
   logic        underflow_err;
   logic        timeout_err;
`ifdef FFT_FRAME_CTRL_PEAK_EN
   logic [9:0]  peak_index;
   logic [9:0]  peak_abs;
   logic        peak_valid;
`endif

   int     n_tests = 0;
   int     n_fail  = 0;
   int     fcount  = 0;
   int     rd_pulses = 0;
   int     fd_pulses = 0;
   int     wr_viol = 0;
   bit     prev_full = 1'b0;
   bit     tick_on = 1'b0;
   int     tick_cnt = 0;
   bit     armed = 1'b0;
   longint arm_t = 0;

   fft_frame_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .enable          (enable),
      .tick_640k       (tick_640k),
      .fifo_data_count (fifo_data_count),
      .fifo_full       (fifo_full),
      .fifo_empty      (fifo_empty),
      .fft_rfd         (fft_rfd),
      .fft_xn_index    (fft_xn_index),
      .fft_done        (fft_done),
      .fft_dv          (fft_dv),
      .fft_xk_index    (fft_xk_index),
      .fft_abs         (fft_abs),
      .fifo_wr_en      (fifo_wr_en),
      .fifo_rd_en      (fifo_rd_en),
      .fft_start       (fft_start),
      .frame_done      (frame_done),
      .frame_count     (frame_count),
      .state_o         (state_o),
      .overflow_err    (overflow_err),
      .underflow_err   (underflow_err),
      .timeout_err     (timeout_err)
`ifdef FFT_FRAME_CTRL_PEAK_EN
      ,
      .peak_index      (peak_index),
      .peak_abs        (peak_abs),
      .peak_valid      (peak_valid)
`endif
   );

   always #(CLK_P / 2) clk = ~clk;

   // sample strobe: one clk high every third clk
   always @(negedge clk) begin
      #1;
      if (tick_on) begin
         tick_640k = (tick_cnt == 0);
         tick_cnt  = (tick_cnt == 2) ? 0 : tick_cnt + 1;
      end else begin
         tick_640k = 1'b0;
      end
   end

   // FIFO occupancy model; counts the write/read that the coming posedge performs
   always @(negedge clk) begin
      #4;
      if (fifo_wr_en && prev_full) wr_viol++;
      if (fifo_wr_en && fcount < 1024) fcount++;
      if (fifo_rd_en && fcount > 0) fcount--;
      if (fifo_rd_en) rd_pulses++;
      if (frame_done) fd_pulses++;
      fifo_data_count = 11'(fcount);
      fifo_full       = (fcount >= 1024);
      fifo_empty      = (fcount == 0);
      prev_full       = fifo_full;
      if (state_o == 3'd1 && fcount >= 1023) begin
         if (!armed) begin
            armed = 1'b1;
            arm_t = $time;
         end
      end else begin
         armed = 1'b0;
      end
   end

   initial begin
      #(CLK_P * 200000);
      $display("FAIL global_timeout: sim still running, required finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic next_cyc();
      @(negedge clk);
      #3;
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
      int n;
      n = 0;
      while (state_o != s && n < budget) begin
         next_cyc();
         n++;
      end
      check_eq(tag, 32'(state_o), 32'(s));
   endtask

   function automatic logic [9:0] bin_abs(input int b, input bit pk);
      if (!pk) return 10'd50;
      if (b == 37 || b == 80) return 10'd300;
      if (b == 0) return 10'd1000;
      if (b == 700) return 10'd999;
      return 10'd50;
   endfunction

   task automatic run_frame(input bit give_done, input bit pk);
      int n;
      int rd0;
      int fd0;
      bit early;
      n = 0;
      while (!fft_start && n < 20000) begin
         next_cyc();
         n++;
      end
      check_eq("start_seen", 32'(fft_start), 32'd1);
      check_eq("start_lat", 32'($time - arm_t), 32'(CLK_P - 1));
      rd0 = rd_pulses;
      for (int i = 0; i < 1024; i++) begin
         fft_rfd      = 1'b1;
         fft_xn_index = 10'(i);
         next_cyc();
      end
      fft_rfd      = 1'b0;
      fft_xn_index = '0;
      check_eq("rd_pulses", 32'(rd_pulses - rd0), 32'd1024);
      check_eq("wait_state", 32'(state_o), 32'd3);
      check_eq("start_drop", 32'(fft_start), 32'd0);
      if (!give_done) return;
      repeat (4) next_cyc();
      fft_done = 1'b1;
      next_cyc();
      fft_done = 1'b0;
      check_eq("unload_state", 32'(state_o), 32'd4);
      fd0   = fd_pulses;
      early = 1'b0;
      for (int b = 0; b < 1024; b++) begin
         fft_dv       = 1'b1;
         fft_xk_index = 10'(b);
         fft_abs      = bin_abs(b, pk);
         next_cyc();
         if (b < 1023 && frame_done) early = 1'b1;
      end
      fft_dv = 1'b0;
      check_eq("frame_done", 32'(frame_done), 32'd1);
      check_eq("fd_early", 32'(early), 32'd0);
`ifdef FFT_FRAME_CTRL_PEAK_EN
      if (pk) begin
         check_eq("peak_valid", 32'(peak_valid), 32'd1);
         check_eq("peak_index", 32'(peak_index), 32'd37);
         check_eq("peak_abs", 32'(peak_abs), 32'd300);
      end
`endif
      next_cyc();
      next_cyc();
      check_eq("fd_once", 32'(fd_pulses - fd0), 32'd1);
   endtask

   initial begin
      reset        = 1'b0;
      enable       = 1'b0;
      fft_rfd      = 1'b0;
      fft_xn_index = '0;
      fft_done     = 1'b0;
      fft_dv       = 1'b0;
      fft_xk_index = '0;
      fft_abs      = '0;
      repeat (3) next_cyc();
      check_eq("rst_state", 32'(state_o), 32'd0);
      check_eq("rst_start", 32'(fft_start), 32'd0);
      check_eq("rst_wr", 32'(fifo_wr_en), 32'd0);
      check_eq("rst_count", 32'(frame_count), 32'd0);
      check_eq("rst_flags", 32'({overflow_err, underflow_err, timeout_err}), 32'd0);

      // get into LOAD quickly with a preloaded FIFO, force an underflow, then reset mid-LOAD
      reset  = 1'b1;
      fcount = 1023;
      enable = 1'b1;
      wait_state(3'd2, 20, "reach_load");
      fft_rfd      = 1'b1;
      fft_xn_index = 10'd0;
      next_cyc();
      fft_xn_index = 10'd1;
      fcount       = 0;
      next_cyc();
      fft_xn_index = 10'd2;
      next_cyc();
      next_cyc();
      check_eq("underflow", 32'(underflow_err), 32'd1);
      check_eq("load_hold", 32'(state_o), 32'd2);
      reset = 1'b0;
      #1;
      check_eq("mid_rst_state", 32'(state_o), 32'd0);
      check_eq("mid_rst_start", 32'(fft_start), 32'd0);
      check_eq("mid_rst_count", 32'(frame_count), 32'd0);
      check_eq("mid_rst_flags", 32'({overflow_err, underflow_err, timeout_err}), 32'd0);
      check_eq("mid_rst_rd", 32'(fifo_rd_en), 32'd0);
      fft_rfd      = 1'b0;
      fft_xn_index = '0;
      enable       = 1'b0;
      repeat (3) next_cyc();
      fcount = 0;
      reset  = 1'b1;
      next_cyc();
      next_cyc();
      check_eq("idle_no_en", 32'(state_o), 32'd0);

      // continuous streaming: three frames back to back
      enable  = 1'b1;
      tick_on = 1'b1;
      run_frame(1'b1, 1'b1);
      check_eq("count_1", 32'(frame_count), 32'd1);
      check_eq("rearm_fill", 32'(state_o), 32'd1);
      run_frame(1'b1, 1'b0);
      run_frame(1'b1, 1'b0);
      check_eq("count_3", 32'(frame_count), 32'd3);
      check_eq("no_flags", 32'({overflow_err, underflow_err, timeout_err}), 32'd0);

      // FFT never finishes: watchdog fires while the FIFO overflows behind it
      run_frame(1'b0, 1'b0);
      repeat (8191) next_cyc();
      check_eq("to_before", 32'(state_o), 32'd3);
      next_cyc();
      check_eq("to_state", 32'(state_o), 32'd1);
      check_eq("to_err", 32'(timeout_err), 32'd1);
      check_eq("to_start", 32'(fft_start), 32'd0);
      check_eq("to_count", 32'(frame_count), 32'd3);
      check_eq("to_no_fd", 32'(frame_done), 32'd0);
      check_eq("overflow", 32'(overflow_err), 32'd1);
      check_eq("wr_blocked", 32'(fifo_wr_en), 32'd0);
      check_eq("wr_when_full", 32'(wr_viol), 32'd0);
      check_eq("to_no_underflow", 32'(underflow_err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
